// File: rtl/irrigation_if.sv
// irrigation_if: sensor inputs and display-stage outputs of the irrigation controller
// Members: Lb/Lm/La reservoir levels (low/middle/high), Us soil dry, Ta temperature high,
//          Bs/Vs sprinkler/drip running (active-low), Ve inlet valve open, ERRO fault flag,
//          Tick_Min minute pulse, Fim_Ciclo cycle-complete pulse.
// master drives the sensors and observes the outputs; slave is the controller side.
interface irrigation_if;
    logic Lb, Lm, La, Us, Ta;
    logic Bs, Vs, Ve, ERRO, Tick_Min, Fim_Ciclo;
    modport master (output Lb, Lm, La, Us, Ta, input Bs, Vs, Ve, ERRO, Tick_Min, Fim_Ciclo);
    modport slave (input Lb, Lm, La, Us, Ta, output Bs, Vs, Ve, ERRO, Tick_Min, Fim_Ciclo);
endinterface

// File: rtl/irrigation_controller.sv
// irrigation_controller: timed sprinkler/drip cycles, inlet valve hysteresis and sensor fault flag
// Ports: Clk clock; Rst synchronous active-low reset; io (irrigation_if.slave) sensors in,
//        registered outputs Bs/Vs (active-low running), Ve, ERRO, Tick_Min, Fim_Ciclo.
// Optional: define FILL_WATCHDOG_EN to latch a fault when the inlet stays open for
//           FILL_TIMEOUT_MIN minutes without any level sensor rising (cleared by reset only).
module irrigation_controller #(
    parameter int CLK_PER_MIN      = 60,
    parameter int ASP_MIN          = 30,
    parameter int GOT_MIN          = 15,
    parameter int FILL_TIMEOUT_MIN = 20
) (
    input logic        Clk,
    input logic        Rst,
    irrigation_if.slave io
);
    localparam int MAX_AG  = ASP_MIN > GOT_MIN ? ASP_MIN : GOT_MIN;
    localparam int MAX_MIN = MAX_AG > FILL_TIMEOUT_MIN ? MAX_AG : FILL_TIMEOUT_MIN;
    localparam int MW      = MAX_MIN > 2 ? $clog2(MAX_MIN) : 1;
    localparam int PW      = CLK_PER_MIN > 2 ? $clog2(CLK_PER_MIN) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MIN - 1);
    localparam logic [MW-1:0] ASP_LAST = MW'(ASP_MIN - 1);
    localparam logic [MW-1:0] GOT_LAST = MW'(GOT_MIN - 1);

    typedef enum logic [1:0] {OCIOSO, ASPERSAO, GOTEJAMENTO, FALHA} state_t;

    state_t        state, nxt;
    logic [PW-1:0] pre;
    logic [MW-1:0] mins;
    logic          fault, done, fim_d, ve_d, trip, latched;

    // Level sensors must be nested: a higher sensor wet with a lower one dry is impossible.
    assign fault = (io.La & ~io.Lm) | (io.La & ~io.Lb) | (io.Lm & ~io.Lb);
    assign done  = io.Tick_Min && mins == (state == ASPERSAO ? ASP_LAST : GOT_LAST);

`ifdef FILL_WATCHDOG_EN
    localparam int FW = $clog2(FILL_TIMEOUT_MIN + 1);
    logic [FW-1:0] fill;
    logic [2:0]    lvl_q;
    logic          rise;

    assign rise = |({io.Lb, io.Lm, io.La} & ~lvl_q);
    // Trip on the edge that would count the final minute of an unproductive fill.
    assign trip = io.Ve && io.Tick_Min && !rise && fill == FW'(FILL_TIMEOUT_MIN - 1);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fill    <= '0;
            lvl_q   <= '0;
            latched <= 1'b0;
        end else begin
            lvl_q   <= {io.Lb, io.Lm, io.La};
            latched <= latched | trip;
            fill    <= (!io.Ve || rise) ? '0 : fill + FW'(io.Tick_Min);
        end
    end
`else
    assign trip    = 1'b0;
    assign latched = 1'b0;
`endif

    always_comb begin
        nxt   = state;
        fim_d = 1'b0;
        if (fault || trip || latched)
            nxt = FALHA;
        else
            case (state)
                OCIOSO:
                    if (io.Us && io.Ta && io.Lm) nxt = ASPERSAO;
                    else if (io.Us && !io.Ta && io.Lb) nxt = GOTEJAMENTO;
                ASPERSAO, GOTEJAMENTO:
                    if (!io.Lb) nxt = OCIOSO;
                    else if (done) begin
                        nxt   = OCIOSO;
                        fim_d = 1'b1;
                    end
                default: nxt = OCIOSO;
            endcase
        ve_d = nxt == FALHA ? 1'b0 : !io.Lm ? 1'b1 : io.La ? 1'b0 : io.Ve;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= OCIOSO;
            pre          <= '0;
            mins         <= '0;
            io.Tick_Min  <= 1'b0;
            io.Fim_Ciclo <= 1'b0;
            io.Bs        <= 1'b1;
            io.Vs        <= 1'b1;
            io.Ve        <= 1'b0;
            io.ERRO      <= 1'b0;
        end else begin
            state        <= nxt;
            pre          <= pre == PRE_LAST ? '0 : pre + 1'b1;
            io.Tick_Min  <= pre == PRE_LAST;
            // Counting only while staying in a cycle also clears it on every entry.
            mins         <= (nxt == state && (state == ASPERSAO || state == GOTEJAMENTO))
                            ? mins + MW'(io.Tick_Min) : '0;
            io.Fim_Ciclo <= fim_d;
            io.Bs        <= nxt != ASPERSAO;
            io.Vs        <= nxt != GOTEJAMENTO;
            io.Ve        <= ve_d;
            io.ERRO      <= nxt == FALHA;
        end
    end
endmodule

// File: tb/tb_irrigation_controller.sv
// tb_irrigation_controller: self-checking bench for irrigation_controller (CLK_PER_MIN=4)
// Ports: none; drives an irrigation_if instance and the Clk/Rst of the controller.
// Watchdog sequence runs only when FILL_WATCHDOG_EN is defined.
module tb_irrigation_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   inv_viol = 0;

    irrigation_if io ();

    irrigation_controller #(
        .CLK_PER_MIN(4), .ASP_MIN(30), .GOT_MIN(15), .FILL_TIMEOUT_MIN(3)
    ) dut (
        .Clk(clk), .Rst(rst), .io(io)
    );

    always #5 clk = ~clk;

    // {rst, Lb, Lm, La, Us, Ta} applied for one edge -> expected {Bs, Vs, Ve, ERRO}
    typedef struct packed {
        logic [5:0] in;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst && io.Bs === 1'b0 && io.Vs === 1'b0) inv_viol++;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int first_tick, low, tks, fims, vs_low, bs_low, raised, early;
        logic fin, fim_end, dropped;
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = '0;
        tbl[0]  = '{6'b0_000_00, 4'b1100};
        tbl[1]  = '{6'b1_111_00, 4'b1100};
        tbl[2]  = '{6'b1_100_00, 4'b1110};
        tbl[3]  = '{6'b1_110_00, 4'b1110};
        tbl[4]  = '{6'b1_111_00, 4'b1100};
        tbl[5]  = '{6'b1_110_00, 4'b1100};
        tbl[6]  = '{6'b1_001_00, 4'b1101};
        tbl[7]  = '{6'b1_001_00, 4'b1101};
        tbl[8]  = '{6'b1_110_00, 4'b1100};
        tbl[9]  = '{6'b1_110_11, 4'b0100};
        tbl[10] = '{6'b1_110_00, 4'b0100};
        tbl[11] = '{6'b1_100_00, 4'b0110};
        tbl[12] = '{6'b1_000_00, 4'b1110};
        tbl[13] = '{6'b1_100_11, 4'b1110};
        tbl[14] = '{6'b1_100_10, 4'b1010};
        tbl[15] = '{6'b1_010_10, 4'b1101};
        tbl[16] = '{6'b1_000_00, 4'b1110};
        tbl[17] = '{6'b1_111_10, 4'b1000};
        tbl[18] = '{6'b1_011_10, 4'b1101};
        tbl[19] = '{6'b0_011_10, 4'b1100};
        tbl[20] = '{6'b1_111_00, 4'b1100};
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            {rst, io.Lb, io.Lm, io.La, io.Us, io.Ta} = tbl[i].in;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'({io.Bs, io.Vs, io.Ve, io.ERRO}), 32'(tbl[i].exp));
        end

        // Full sprinkler cycle started straight out of reset.
        @(negedge clk);
        rst = 1'b0;
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b11111;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({io.Bs, io.Vs, io.Ve, io.ERRO, io.Tick_Min, io.Fim_Ciclo}), 32'b110000);
        rst = 1'b1;
        first_tick = 0; low = 0; tks = 0; fims = 0; vs_low = 0; fin = 1'b0; fim_end = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            @(negedge clk);
            if (io.Tick_Min && first_tick == 0) first_tick = k;
            if (!io.Vs) vs_low++;
            if (io.Fim_Ciclo) fims++;
            if (!io.Bs) begin
                low++;
                if (io.Tick_Min) tks++;
            end else if (low > 0) begin
                fin = 1'b1;
                fim_end = io.Fim_Ciclo;
                io.Us = 1'b0;
            end
        end
        chk("asp_finished", 32'(fin), 1);
        chk("first_tick_cycle", first_tick, 4);
        chk("asp_bs_low_cycles", low, 120);
        chk("asp_ticks", tks, 30);
        chk("asp_fim_pulses", fims, 1);
        chk("asp_fim_at_end", 32'(fim_end), 1);
        chk("asp_vs_low", vs_low, 0);
        @(negedge clk);
        chk("idle_after_asp", 32'(io.Bs), 1);

        // Drip cycle with the tank refilled part-way through.
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b10010;
        low = 0; tks = 0; fims = 0; bs_low = 0; raised = 0; fin = 1'b0; fim_end = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge clk);
            if (!io.Bs) bs_low++;
            if (io.Fim_Ciclo) fims++;
            if (!io.Vs) begin
                low++;
                if (io.Tick_Min) tks++;
                if (raised == 1) begin
                    chk("drip_ve_closed", 32'(io.Ve), 0);
                    raised = 2;
                end
                if (tks == 5 && raised == 0) begin
                    chk("drip_ve_open", 32'(io.Ve), 1);
                    io.Lm = 1'b1;
                    io.La = 1'b1;
                    raised = 1;
                end
            end else if (low > 0) begin
                fin = 1'b1;
                fim_end = io.Fim_Ciclo;
                io.Us = 1'b0;
            end
        end
        chk("drip_finished", 32'(fin), 1);
        chk("drip_ticks", tks, 15);
        chk("drip_fim_at_end", 32'(fim_end), 1);
        chk("drip_fim_pulses", fims, 1);
        chk("drip_bs_low", bs_low, 0);
        chk("drip_refill_seen", raised, 2);

        // Inconsistent levels during a sprinkler cycle, then recovery.
        @(negedge clk);
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b11111;
        repeat (3) @(negedge clk);
        chk("asp_running", 32'(io.Bs), 0);
        {io.Lb, io.Lm, io.La} = 3'b101;
        @(negedge clk);
        chk("fault_outputs", 32'({io.Bs, io.Vs, io.Ve, io.ERRO}), 32'b1101);
        {io.Lb, io.Lm, io.La, io.Us} = 4'b1110;
        @(negedge clk);
        chk("fault_recover", 32'({io.Bs, io.Vs, io.Ve, io.ERRO}), 32'b1100);
        @(negedge clk);
        chk("idle_after_fault", 32'({io.Bs, io.Vs, io.ERRO}), 32'b110);

        // Dry abort at the seventh minute of a drip cycle.
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b10010;
        tks = 0; dropped = 1'b0; fin = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge clk);
            if (dropped) begin
                chk("dry_abort_vs", 32'(io.Vs), 1);
                chk("dry_abort_no_fim", 32'(io.Fim_Ciclo), 0);
                io.Us = 1'b0;
                fin = 1'b1;
            end else if (!io.Vs && io.Tick_Min) begin
                tks++;
                if (tks == 7) begin
                    {io.Lb, io.Lm, io.La} = 3'b000;
                    dropped = 1'b1;
                end
            end
        end
        chk("dry_abort_reached", 32'(fin), 1);
        @(negedge clk);
        chk("dry_abort_stays_idle", 32'({io.Vs, io.Fim_Ciclo}), 32'b10);

        // Reset in the middle of a drip cycle with the inlet open.
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b10010;
        repeat (6) @(negedge clk);
        chk("drip_before_reset", 32'({io.Vs, io.Ve}), 32'b01);
        rst = 1'b0;
        @(negedge clk);
        chk("midcycle_reset", 32'({io.Bs, io.Vs, io.Ve, io.ERRO, io.Tick_Min, io.Fim_Ciclo}), 32'b110000);
        rst = 1'b1;
        io.Us = 1'b0;

`ifdef FILL_WATCHDOG_EN
        // Inlet open with no level ever rising: latched fault after three minutes.
        @(negedge clk);
        rst = 1'b0;
        {io.Lb, io.Lm, io.La, io.Us, io.Ta} = 5'b00000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tks = 0; early = 0; fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (tks == 3) begin
                chk("wd_erro_set", 32'(io.ERRO), 1);
                fin = 1'b1;
            end else begin
                if (io.ERRO) early++;
                if (io.Tick_Min) tks++;
            end
        end
        chk("wd_reached", 32'(fin), 1);
        chk("wd_not_early", early, 0);
        {io.Lb, io.Lm, io.La} = 3'b111;
        repeat (8) @(negedge clk);
        chk("wd_latched", 32'({io.ERRO, io.Ve}), 32'b10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wd_cleared_by_reset", 32'(io.ERRO), 0);
`endif

        chk("bs_vs_exclusive", inv_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
